// File: rtl/jtag_scan_master.sv
// JTAG host: turns TAP_RESET/IR/DR/IDLE_CLK commands into TCK/TMS/TDI slots and returns captured TDO.
// Latency (len+5|6 (+6 if unsynced)) * 2*CLK_DIV + 1 clk to rsp_valid; cmd_ready only when idle, no rsp backpressure.
module jtag_scan_master #(
  parameter int CLK_DIV = 5,
  parameter int MAX_LEN = 64,
  localparam int LEN_W = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_tdi,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_tdo,
  output logic               rsp_err,
  output logic               busy,
  output logic               tap_synced,
  output logic               jtag_tck_o,
  output logic               jtag_tms_o,
  output logic               jtag_tdi_o,
  input  logic               jtag_tdo_i
);

  localparam int DIV_W = (2 * CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

  localparam logic [1:0] OP_TAP_RESET = 2'd0;
  localparam logic [1:0] OP_IR        = 2'd1;
  localparam logic [1:0] OP_DR        = 2'd2;
  localparam logic [1:0] OP_IDLE      = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE_RESET,
    S_NAV_IN,
    S_SHIFT,
    S_NAV_OUT,
    S_RESP
  } state_t;

  state_t               state_q, state_d;
  logic [DIV_W-1:0]     div_q;
  logic [LEN_W-1:0]     idx_q;
  logic [LEN_W-1:0]     len_q;
  logic [1:0]           op_q;
  logic [MAX_LEN-1:0]   data_q;
  logic [MAX_LEN-1:0]   cap_q;
  logic                 err_q;
  logic                 synced_q, synced_d;
  logic                 rdy_en_q;
  logic                 tck_q, tms_q, tdi_q;
  logic                 rsp_valid_q, rsp_err_q;
  logic [MAX_LEN-1:0]   rsp_tdo_q;

  logic                 accept, len_bad, slot_end, phase_last, is_scan;
  logic                 slot_tms, slot_tdi;
  logic [LEN_W-1:0]     phase_len;

  assign cmd_ready  = rdy_en_q && (state_q == S_IDLE) && !rsp_valid_q;
  assign accept     = cmd_valid && cmd_ready;
  assign len_bad    = (cmd_len == '0) || (cmd_len > LEN_MAX);
  assign slot_end   = (div_q == DIV_LAST);
  assign phase_last = (idx_q == phase_len - LEN_ONE);
  assign is_scan    = (op_q != OP_IDLE);

  assign busy       = (state_q != S_IDLE);
  assign tap_synced = synced_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_tdo    = rsp_tdo_q;
  assign rsp_err    = rsp_err_q;
  assign jtag_tck_o = tck_q;
  assign jtag_tms_o = tms_q;
  assign jtag_tdi_o = tdi_q;

  always_comb begin
    phase_len = len_q;
    case (state_q)
      S_PRE_RESET: phase_len = LEN_W'(6);
      S_NAV_IN:    phase_len = (op_q == OP_IR) ? LEN_W'(4) : LEN_W'(3);
      S_NAV_OUT:   phase_len = LEN_W'(2);
      default:     phase_len = len_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    synced_d = synced_q;
    slot_tms = 1'b0;
    slot_tdi = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_TAP_RESET: state_d = S_PRE_RESET;
            OP_IDLE:      state_d = (cmd_len == '0) ? S_RESP : S_SHIFT;
            default: begin
              if (len_bad)       state_d = S_RESP;
              else if (synced_q) state_d = S_NAV_IN;
              else               state_d = S_PRE_RESET;
            end
          endcase
        end
      end
      S_PRE_RESET: begin
        slot_tms = (idx_q < LEN_W'(5));
        if (slot_end && phase_last) begin
          synced_d = 1'b1;
          state_d  = (op_q == OP_TAP_RESET) ? S_RESP : S_NAV_IN;
        end
      end
      S_NAV_IN: begin
        // IR path goes through Select-DR first, hence one extra TMS=1
        slot_tms = (op_q == OP_IR) ? (idx_q < LEN_W'(2)) : (idx_q == '0);
        if (slot_end && phase_last) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        slot_tms = is_scan && phase_last;
        slot_tdi = is_scan && data_q[0];
        if (slot_end && phase_last) state_d = is_scan ? S_NAV_OUT : S_RESP;
      end
      S_NAV_OUT: begin
        slot_tms = (idx_q == '0);
        if (slot_end && phase_last) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      idx_q       <= '0;
      len_q       <= '0;
      op_q        <= OP_TAP_RESET;
      data_q      <= '0;
      cap_q       <= '0;
      err_q       <= 1'b0;
      synced_q    <= 1'b0;
      rdy_en_q    <= 1'b0;
      tck_q       <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_tdo_q   <= '0;
    end else begin
      state_q     <= state_d;
      synced_q    <= synced_d;
      rdy_en_q    <= 1'b1;
      rsp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          tck_q <= 1'b0;
          tdi_q <= 1'b0;
          if (accept) begin
            op_q   <= cmd_op;
            len_q  <= (cmd_op == OP_IDLE && cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;
            data_q <= cmd_tdi;
            cap_q  <= '0;
            err_q  <= (cmd_op == OP_IR || cmd_op == OP_DR) && len_bad;
            div_q  <= '0;
            idx_q  <= '0;
          end
        end
        S_RESP: begin
          tck_q       <= 1'b0;
          tdi_q       <= 1'b0;
          rsp_valid_q <= 1'b1;
          rsp_tdo_q   <= cap_q;
          rsp_err_q   <= err_q;
        end
        default: begin
          // pins trail the divider by one clk so every half-slot is exactly CLK_DIV cycles wide
          tck_q <= (div_q >= DIV_HALF);
          tms_q <= slot_tms;
          tdi_q <= slot_tdi;
          if (state_q == S_SHIFT && is_scan && div_q == DIV_HALF)
            cap_q <= cap_q | (MAX_LEN'(jtag_tdo_i) << idx_q);
          if (slot_end) begin
            div_q <= '0;
            idx_q <= phase_last ? '0 : idx_q + LEN_ONE;
            if (state_q == S_SHIFT) data_q <= data_q >> 1;
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_scan_master.sv
// Bench for jtag_scan_master: slot-level model of TMS/TDI/TDO sequences plus per-cycle pin checks.
module tb_jtag_scan_master;

  localparam int CLK_DIV = 5;
  localparam int MAX_LEN = 64;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic               clk = 1'b0;
  logic               rst_n;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [LEN_W-1:0]   cmd_len;
  logic [MAX_LEN-1:0] cmd_tdi;
  logic               rsp_valid;
  logic [MAX_LEN-1:0] rsp_tdo;
  logic               rsp_err;
  logic               busy;
  logic               tap_synced;
  logic               jtag_tck_o, jtag_tms_o, jtag_tdi_o;
  logic               jtag_tdo_i = 1'b0;

  jtag_scan_master #(.CLK_DIV(CLK_DIV), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_tdi(cmd_tdi),
    .rsp_valid(rsp_valid), .rsp_tdo(rsp_tdo), .rsp_err(rsp_err),
    .busy(busy), .tap_synced(tap_synced),
    .jtag_tck_o(jtag_tck_o), .jtag_tms_o(jtag_tms_o), .jtag_tdi_o(jtag_tdi_o), .jtag_tdo_i(jtag_tdo_i)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // TAP-side recorder: pins seen at each TCK rise; TDO changes on TCK fall like a real TAP
  bit   rec_tms[$];
  bit   rec_tdi[$];
  int   rise_cnt = 0;
  int   base_rise = 0;
  int   tdo_idx;
  logic [127:0] tdo_pat = '0;
  event pat_loaded;

  always @(posedge jtag_tck_o) begin
    rec_tms.push_back(jtag_tms_o);
    rec_tdi.push_back(jtag_tdi_o);
    rise_cnt = rise_cnt + 1;
  end

  always begin
    @(negedge jtag_tck_o or pat_loaded);
    tdo_idx = rise_cnt - base_rise;
    jtag_tdo_i = (tdo_idx >= 0 && tdo_idx < 128) ? tdo_pat[tdo_idx] : 1'b0;
  end

  // slot-level expectations for the command in flight
  bit           exp_tms[$];
  bit           exp_tdi[$];
  bit           exp_err;
  logic [63:0]  exp_tdo;
  int           exp_lat;
  int           base_q;
  bit           m_synced = 1'b0;
  bit           outstanding = 1'b0;
  bit           done = 1'b0;
  int           last_lat;

  // per-cycle tracking
  int hi_run, lo_run;
  bit seen_fall, prev_tck, prev_tms, prev_tdi;

  task automatic chk_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_slot(input bit t, input bit d);
    exp_tms.push_back(t);
    exp_tdi.push_back(d);
  endtask

  task automatic issue_cmd(input logic [1:0] op, input int len, input logic [63:0] tdi, input logic [127:0] pat);
    int sstart;
    int n;
    int k;
    exp_tms.delete();
    exp_tdi.delete();
    exp_err = 1'b0;
    exp_tdo = '0;
    sstart  = -1;
    case (op)
      2'd0: begin
        for (int i = 0; i < 6; i++) push_slot(i < 5, 1'b0);
        m_synced = 1'b1;
      end
      2'd1, 2'd2: begin
        if (len < 1 || len > MAX_LEN) exp_err = 1'b1;
        else begin
          if (!m_synced) for (int i = 0; i < 6; i++) push_slot(i < 5, 1'b0);
          push_slot(1'b1, 1'b0);
          if (op == 2'd1) push_slot(1'b1, 1'b0);
          push_slot(1'b0, 1'b0);
          push_slot(1'b0, 1'b0);
          sstart = exp_tms.size();
          for (int i = 0; i < len; i++) push_slot(i == len - 1, tdi[i]);
          push_slot(1'b1, 1'b0);
          push_slot(1'b0, 1'b0);
          m_synced = 1'b1;
        end
      end
      default: begin
        n = (len > MAX_LEN) ? MAX_LEN : len;
        for (int i = 0; i < n; i++) push_slot(1'b0, 1'b0);
      end
    endcase
    if (sstart >= 0) for (int i = 0; i < len; i++) exp_tdo[i] = pat[sstart + i];
    exp_lat = exp_tms.size() * 2 * CLK_DIV + 1;

    k = 0;
    @(negedge clk);
    while (!cmd_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk_eq("cmd_ready_wait", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = LEN_W'(len);
    cmd_tdi   = tdi;
    tdo_pat   = pat;
    base_q    = rec_tms.size();
    base_rise = rise_cnt;
    -> pat_loaded;
    @(posedge clk);
    #1;
    cmd_valid   = 1'b0;
    cmd_op      = ~op;
    cmd_len     = ~cmd_len;
    cmd_tdi     = ~tdi;
    outstanding = 1'b1;
  endtask

  task automatic finish_cmd();
    int k;
    bit got;
    int mism;
    k = 0;
    got = 1'b0;
    while (!got && k < 2000) begin
      @(negedge clk);
      if (rsp_valid) got = 1'b1;
      else k++;
    end
    chk_eq("rsp_seen", got, 1);
    last_lat = k;
    chk_eq("latency", k, exp_lat);
    chk_eq("rsp_err", rsp_err, exp_err);
    chk_eq("rsp_tdo", rsp_tdo, exp_tdo);
    chk_eq("tap_synced", tap_synced, m_synced);
    chk_eq("rise_count", rec_tms.size() - base_q, exp_tms.size());
    mism = 0;
    for (int i = 0; i < exp_tms.size(); i++) begin
      if (base_q + i >= rec_tms.size()) mism++;
      else if (rec_tms[base_q + i] != exp_tms[i] || rec_tdi[base_q + i] != exp_tdi[i]) mism++;
    end
    chk_eq("tms_tdi_seq", mism, 0);
    #1 outstanding = 1'b0;
    @(negedge clk);
    chk_eq("ready_after_rsp", cmd_ready, 1);
    chk_eq("rsp_tdo_held", rsp_tdo, exp_tdo);
  endtask

  function automatic logic [5:0] first6_tms();
    logic [5:0] v;
    v = '0;
    for (int i = 0; i < 6; i++) if (base_q + i < rec_tms.size()) v[i] = rec_tms[base_q + i];
    return v;
  endfunction

  task automatic check_reset_state(input string tag);
    chk_eq({tag, "_tck"}, jtag_tck_o, 0);
    chk_eq({tag, "_tms"}, jtag_tms_o, 1);
    chk_eq({tag, "_tdi"}, jtag_tdi_o, 0);
    chk_eq({tag, "_ready"}, cmd_ready, 0);
    chk_eq({tag, "_rsp_valid"}, rsp_valid, 0);
    chk_eq({tag, "_rsp_tdo"}, rsp_tdo, 0);
    chk_eq({tag, "_rsp_err"}, rsp_err, 0);
    chk_eq({tag, "_busy"}, busy, 0);
    chk_eq({tag, "_synced"}, tap_synced, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_len   = '0;
    cmd_tdi   = '0;
    fork
      begin : per_cycle
        while (!done) begin
          @(negedge clk);
          if (!rst_n) begin
            hi_run = 0; lo_run = 0; seen_fall = 1'b0;
          end else begin
            chk_eq("idle_pins_quiet", busy ? 2'b00 : {jtag_tck_o, jtag_tdi_o}, 0);
            chk_eq("ready_while_busy", cmd_ready & busy, 0);
            chk_eq("rsp_unexpected", rsp_valid & (cmd_ready | !outstanding), 0);
            chk_eq("pin_change_tck_high", jtag_tck_o & ((jtag_tms_o ^ prev_tms) | (jtag_tdi_o ^ prev_tdi)), 0);
            if (jtag_tck_o && !prev_tck) begin
              if (seen_fall) chk_eq("tck_low_half", lo_run, CLK_DIV);
              hi_run = 1;
            end else if (!jtag_tck_o && prev_tck) begin
              chk_eq("tck_high_half", hi_run, CLK_DIV);
              seen_fall = 1'b1;
              lo_run = 1;
            end else if (jtag_tck_o) hi_run++;
            else lo_run++;
            if (!busy) seen_fall = 1'b0;
          end
          prev_tck = jtag_tck_o;
          prev_tms = jtag_tms_o;
          prev_tdi = jtag_tdi_o;
        end
      end
      begin : sequence_main
        int cnt;
        #12;
        check_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;

        issue_cmd(2'd2, 0, 64'h0, 128'h0);
        finish_cmd();
        chk_eq("lit_len0_err", rsp_err, 1);
        chk_eq("lit_len0_synced", tap_synced, 0);

        issue_cmd(2'd0, 0, 64'h0, 128'h0);
        finish_cmd();
        chk_eq("lit_reset_tms", first6_tms(), 6'b011111);
        chk_eq("lit_reset_lat", last_lat, 61);
        chk_eq("lit_reset_synced", tap_synced, 1);

        issue_cmd(2'd2, 8, 64'h3C, 128'h528);
        finish_cmd();
        chk_eq("lit_dr8_tdo", rsp_tdo, 64'hA5);
        chk_eq("lit_dr8_lat", last_lat, 131);

        issue_cmd(2'd1, 8, 64'h11, {$urandom, $urandom, $urandom, $urandom});
        finish_cmd();
        issue_cmd(2'd2, 41, {23'd0, 7'h10, 32'h8000_0001, 2'b10}, {$urandom, $urandom, $urandom, $urandom});
        finish_cmd();
        issue_cmd(2'd2, 41, {23'd0, 7'h11, 32'h0, 2'b01}, {$urandom, $urandom, $urandom, $urandom});
        finish_cmd();
        issue_cmd(2'd2, 64, {$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
        finish_cmd();
        issue_cmd(2'd2, 1, 64'h1, 128'hFFFF_FFFF);
        finish_cmd();
        issue_cmd(2'd2, 65, 64'hFFFF, 128'hFFFF);
        finish_cmd();
        issue_cmd(2'd1, 0, 64'hFFFF, 128'hFFFF);
        finish_cmd();
        issue_cmd(2'd3, 3, 64'hFF, 128'hFF);
        finish_cmd();
        issue_cmd(2'd3, 0, 64'h0, 128'h0);
        finish_cmd();
        chk_eq("lit_idle0_lat", last_lat, 1);
        issue_cmd(2'd3, 100, 64'h0, 128'hFF);
        finish_cmd();
        chk_eq("lit_idle_clamp_lat", last_lat, 641);

        // abort mid-shift with async reset
        issue_cmd(2'd2, 32, 64'hDEAD_BEEF, 128'h0);
        repeat (80) @(posedge clk);
        #1;
        chk_eq("busy_before_abort", busy, 1);
        #1 rst_n = 1'b0;
        #1;
        check_reset_state("abort");
        outstanding = 1'b0;
        m_synced    = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        repeat (30) begin
          @(negedge clk);
          if (rsp_valid) cnt++;
        end
        chk_eq("no_rsp_after_abort", cnt, 0);

        issue_cmd(2'd2, 32, 64'h1234_5678, {$urandom, $urandom, $urandom, $urandom});
        finish_cmd();
        chk_eq("lit_resync_tms", first6_tms(), 6'b011111);
        chk_eq("lit_resync_lat", last_lat, 431);

        done = 1'b1;
      end
    join
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
